// File: rtl/flr_csr_scratch_bank_if.sv
// rtl/flr_csr_scratch_bank_if.sv - CSR request/response bus for the FLR scratch bank
interface flr_csr_scratch_bank_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 64
);
  logic                csr_req_valid;
  logic                csr_req_ready;
  logic                csr_req_write;
  logic [ADDR_W-1:0]   csr_req_addr;
  logic [DATA_W-1:0]   csr_req_wdata;
  logic [DATA_W/8-1:0] csr_req_wstrb;
  logic                csr_rsp_valid;
  logic [DATA_W-1:0]   csr_rsp_rdata;

  modport master (
    output csr_req_valid, csr_req_write, csr_req_addr, csr_req_wdata, csr_req_wstrb,
    input  csr_req_ready, csr_rsp_valid, csr_rsp_rdata
  );

  modport slave (
    input  csr_req_valid, csr_req_write, csr_req_addr, csr_req_wdata, csr_req_wstrb,
    output csr_req_ready, csr_rsp_valid, csr_rsp_rdata
  );
endinterface

// File: rtl/flr_csr_scratch_bank.sv
// rtl/flr_csr_scratch_bank.sv - per-link DFH/scratch/test/FLR-count CSR bank with FLR sequencers
module flr_csr_scratch_bank #(
  parameter int                NUM_LINKS        = 1,
  parameter int                ADDR_W           = 20,
  parameter int                DATA_W           = 64,
  parameter logic [ADDR_W-1:0] BASE_ADDR        = 20'h10000,
  parameter logic [ADDR_W-1:0] LINK_STRIDE      = 20'h1000,
  parameter logic [63:0]       DFH_VALUE        = 64'h3000000010000020,
  parameter logic [63:0]       SCRATCH_RST      = 64'h0,
  parameter int                FLR_CLEAR_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  flr_csr_scratch_bank_if.slave csr,
  input  logic [NUM_LINKS-1:0]  flr_req,
  output logic [NUM_LINKS-1:0]  flr_ack,
  output logic [NUM_LINKS-1:0]  flr_busy
);
  localparam int                STRB_W     = DATA_W / 8;
  localparam int                CNT_W      = (FLR_CLEAR_CYCLES > 1) ? $clog2(FLR_CLEAR_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_RELOAD = CNT_W'(FLR_CLEAR_CYCLES - 1);
  localparam logic [DATA_W-1:0] DFH_RD     = DFH_VALUE[DATA_W-1:0];
  localparam logic [DATA_W-1:0] SCR_RST    = SCRATCH_RST[DATA_W-1:0];

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_ACK   = 2'd2
  } flr_state_e;

  flr_state_e        state_q   [NUM_LINKS];
  flr_state_e        state_d   [NUM_LINKS];
  logic [CNT_W-1:0]  cnt_q     [NUM_LINKS];
  logic [CNT_W-1:0]  cnt_d     [NUM_LINKS];
  logic [DATA_W-1:0] scratch_q [NUM_LINKS];
  logic [DATA_W-1:0] scratch_d [NUM_LINKS];
  logic [DATA_W-1:0] testpad_q [NUM_LINKS];
  logic [DATA_W-1:0] testpad_d [NUM_LINKS];
  logic [15:0]       count_q   [NUM_LINKS];
  logic [15:0]       count_d   [NUM_LINKS];
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic                 accept;
  logic                 wr_acc;
  logic                 rd_acc;
  logic [NUM_LINKS-1:0] hit_dfh, hit_scratch, hit_testpad, hit_count;

  // Address low three bits select bytes within a 64-bit register and never affect the match.
  function automatic logic reg_hit(input logic [ADDR_W-1:0] addr, input int link,
                                   input logic [ADDR_W-1:0] off);
    logic [ADDR_W-1:0] target;
    target = BASE_ADDR + ADDR_W'(link) * LINK_STRIDE + off;
    return ((addr ^ target) & ~ADDR_W'(7)) == '0;
  endfunction

  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_val,
                                                    input logic [DATA_W-1:0] new_val,
                                                    input logic [STRB_W-1:0] strb);
    logic [DATA_W-1:0] res;
    res = old_val;
    for (int b = 0; b < STRB_W; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

  assign csr.csr_req_ready = rst_n;
  assign accept            = csr.csr_req_valid & csr.csr_req_ready;
  assign wr_acc            = accept & csr.csr_req_write;
  assign rd_acc            = accept & ~csr.csr_req_write;
  assign csr.csr_rsp_valid = rsp_valid_q;
  assign csr.csr_rsp_rdata = rdata_q;

  // Decode the request address against every link's register set.
  always_comb begin
    hit_dfh     = '0;
    hit_scratch = '0;
    hit_testpad = '0;
    hit_count   = '0;
    for (int l = 0; l < NUM_LINKS; l++) begin
      hit_dfh[l]     = reg_hit(csr.csr_req_addr, l, ADDR_W'(8'h00));
      hit_scratch[l] = reg_hit(csr.csr_req_addr, l, ADDR_W'(8'h08));
      hit_testpad[l] = reg_hit(csr.csr_req_addr, l, ADDR_W'(8'h28));
      hit_count[l]   = reg_hit(csr.csr_req_addr, l, ADDR_W'(8'h30));
    end
  end

  // FLR sequencer state register, one per link.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int l = 0; l < NUM_LINKS; l++) begin
        state_q[l] <= ST_IDLE;
        cnt_q[l]   <= '0;
      end
    end else begin
      for (int l = 0; l < NUM_LINKS; l++) begin
        state_q[l] <= state_d[l];
        cnt_q[l]   <= cnt_d[l];
      end
    end
  end

  // FLR next state: a request in CLEAR restarts the countdown, a request in ACK is ignored.
  always_comb begin
    for (int l = 0; l < NUM_LINKS; l++) begin
      state_d[l] = state_q[l];
      cnt_d[l]   = cnt_q[l];
      case (state_q[l])
        ST_IDLE: begin
          if (flr_req[l]) begin
            state_d[l] = ST_CLEAR;
            cnt_d[l]   = CNT_RELOAD;
          end
        end
        ST_CLEAR: begin
          if (flr_req[l]) begin
            cnt_d[l] = CNT_RELOAD;
          end else if (cnt_q[l] == '0) begin
            state_d[l] = ST_ACK;
          end else begin
            cnt_d[l] = cnt_q[l] - CNT_W'(1);
          end
        end
        ST_ACK:  state_d[l] = ST_IDLE;
        default: state_d[l] = ST_IDLE;
      endcase
    end
  end

  // FLR status outputs decoded from the current state.
  always_comb begin
    flr_busy = '0;
    flr_ack  = '0;
    for (int l = 0; l < NUM_LINKS; l++) begin
      flr_busy[l] = (state_q[l] == ST_CLEAR);
      flr_ack[l]  = (state_q[l] == ST_ACK);
    end
  end

  // Register file update: FLR entry clears, otherwise byte-masked writes land only while idle.
  always_comb begin
    for (int l = 0; l < NUM_LINKS; l++) begin
      scratch_d[l] = scratch_q[l];
      testpad_d[l] = testpad_q[l];
      count_d[l]   = count_q[l];
      if (state_q[l] == ST_IDLE && flr_req[l]) begin
        scratch_d[l] = SCR_RST;
        testpad_d[l] = '0;
      end else if (state_q[l] == ST_IDLE && wr_acc) begin
        if (hit_scratch[l]) scratch_d[l] = merge_bytes(scratch_q[l], csr.csr_req_wdata, csr.csr_req_wstrb);
        if (hit_testpad[l]) testpad_d[l] = merge_bytes(testpad_q[l], csr.csr_req_wdata, csr.csr_req_wstrb);
      end
      if (state_q[l] == ST_CLEAR && state_d[l] == ST_ACK && count_q[l] != 16'hFFFF) begin
        count_d[l] = count_q[l] + 16'd1;
      end
    end
  end

  // Read mux; anything that decodes to no register reads as zero.
  always_comb begin
    rdata_d     = '0;
    rsp_valid_d = rd_acc;
    if (rd_acc) begin
      for (int l = 0; l < NUM_LINKS; l++) begin
        if (hit_dfh[l])     rdata_d = DFH_RD;
        if (hit_scratch[l]) rdata_d = scratch_q[l];
        if (hit_testpad[l]) rdata_d = testpad_q[l];
        if (hit_count[l])   rdata_d = {{(DATA_W-16){1'b0}}, count_q[l]};
      end
    end
  end

  // Register file and read response storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int l = 0; l < NUM_LINKS; l++) begin
        scratch_q[l] <= SCR_RST;
        testpad_q[l] <= '0;
        count_q[l]   <= '0;
      end
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      for (int l = 0; l < NUM_LINKS; l++) begin
        scratch_q[l] <= scratch_d[l];
        testpad_q[l] <= testpad_d[l];
        count_q[l]   <= count_d[l];
      end
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
    end
  end
endmodule

// File: tb/tb_flr_csr_scratch_bank.sv
// tb/tb_flr_csr_scratch_bank.sv - scoreboard bench for the FLR CSR scratch bank
module tb_flr_csr_scratch_bank;
  localparam int              NL     = 2;
  localparam int              AW     = 20;
  localparam int              DW     = 64;
  localparam int              CLR    = 4;
  localparam int              STRIDE = 'h1000;
  localparam logic [AW-1:0]   BASE   = 20'h10000;
  localparam logic [63:0]     DFH    = 64'h3000000010000020;

  typedef struct { int cyc; logic [63:0] data; } rsp_t;
  typedef struct { int cyc; logic [NL-1:0] busy; logic [NL-1:0] ack; } flr_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NL-1:0] flr_req = '0;
  logic [NL-1:0] flr_ack;
  logic [NL-1:0] flr_busy;
  int            cyc = 0;
  int            n_checks = 0;
  int            n_err = 0;
  bit            mon_en = 1'b0;

  rsp_t rsp_q[$];
  flr_t flr_q[$];

  logic [63:0] m_scr [NL];
  logic [63:0] m_tp  [NL];
  int          m_cnt [NL];
  int          ack_at[NL];
  bit          active[NL];
  bit          counted[NL];

  flr_csr_scratch_bank_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  flr_csr_scratch_bank #(
    .NUM_LINKS(NL), .ADDR_W(AW), .DATA_W(DW), .FLR_CLEAR_CYCLES(CLR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .csr(bus),
    .flr_req(flr_req), .flr_ack(flr_ack), .flr_busy(flr_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int l = 0; l < NL; l++) begin
      m_scr[l] = 64'd0; m_tp[l] = 64'd0; m_cnt[l] = 0;
      ack_at[l] = -1; active[l] = 1'b0; counted[l] = 1'b0;
    end
  endfunction

  // 0 idle, 1 clearing, 2 acknowledging, for link l during cycle k
  function automatic int phase(input int l, input int k);
    if (!active[l]) return 0;
    if (k < ack_at[l]) return 1;
    if (k == ack_at[l]) return 2;
    return 0;
  endfunction

  function automatic void settle(input int k);
    for (int l = 0; l < NL; l++) begin
      if (active[l] && k >= ack_at[l] && !counted[l]) begin
        counted[l] = 1'b1;
        if (m_cnt[l] < 65535) m_cnt[l]++;
      end
    end
  endfunction

  function automatic void decode(input logic [AW-1:0] a, output int l, output int r);
    int off;
    l = -1; r = -1;
    if (a >= BASE) begin
      off = int'(a - BASE);
      if (off / STRIDE < NL) begin
        l = off / STRIDE;
        r = (off % STRIDE) & ~7;
      end
    end
  endfunction

  function automatic logic [63:0] model_read(input int l, input int r);
    if (l < 0) return 64'd0;
    case (r)
      'h00: return DFH;
      'h08: return m_scr[l];
      'h28: return m_tp[l];
      'h30: return 64'(m_cnt[l]);
      default: return 64'd0;
    endcase
  endfunction

  // Drive one cycle of stimulus, advance the model to the sampling edge, queue expectations.
  task automatic step(input bit v, input bit w, input logic [AW-1:0] a, input logic [63:0] d,
                      input logic [7:0] s, input logic [NL-1:0] f);
    int k, e, l, r;
    int ph[NL];
    rsp_t rt;
    flr_t ft;
    logic [63:0] val;
    k = cyc; e = k + 1;
    bus.csr_req_valid = v; bus.csr_req_write = w; bus.csr_req_addr = a;
    bus.csr_req_wdata = d; bus.csr_req_wstrb = s; flr_req = f;
    settle(k);
    for (int i = 0; i < NL; i++) ph[i] = phase(i, k);
    decode(a, l, r);
    if (v && !w) begin
      rt.cyc = e; rt.data = model_read(l, r);
      rsp_q.push_back(rt);
    end
    for (int i = 0; i < NL; i++) begin
      if (f[i] && ph[i] == 0) begin
        active[i] = 1'b1; counted[i] = 1'b0; ack_at[i] = e + CLR;
        m_scr[i] = 64'd0; m_tp[i] = 64'd0;
      end else if (f[i] && ph[i] == 1) begin
        ack_at[i] = e + CLR;
      end
    end
    if (v && w && l >= 0 && ph[l] == 0 && !f[l] && (r == 'h08 || r == 'h28)) begin
      val = (r == 'h08) ? m_scr[l] : m_tp[l];
      for (int b = 0; b < 8; b++) if (s[b]) val[8*b +: 8] = d[8*b +: 8];
      if (r == 'h08) m_scr[l] = val; else m_tp[l] = val;
    end
    ft.cyc = e; ft.busy = '0; ft.ack = '0;
    for (int i = 0; i < NL; i++) begin
      ft.busy[i] = (phase(i, e) == 1);
      ft.ack[i]  = (phase(i, e) == 2);
    end
    flr_q.push_back(ft);
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, 64'd0, 8'h00, '0);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    step(1'b1, 1'b0, a, 64'd0, 8'h00, '0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [63:0] d, input logic [7:0] s);
    step(1'b1, 1'b1, a, d, s, '0);
  endtask

  // Monitor: compares DUT outputs against queued expectations every cycle.
  initial begin : monitor
    rsp_t rt;
    flr_t ft;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (rsp_q.size() > 0 && rsp_q[0].cyc == cyc) begin
          rt = rsp_q.pop_front();
          chk("rsp_valid", 64'(bus.csr_rsp_valid), 64'd1);
          if (bus.csr_rsp_valid) chk("rsp_rdata", bus.csr_rsp_rdata, rt.data);
        end else begin
          chk("rsp_idle", 64'(bus.csr_rsp_valid), 64'd0);
        end
        if (flr_q.size() > 0 && flr_q[0].cyc == cyc) begin
          ft = flr_q.pop_front();
          chk("flr_busy", 64'(flr_busy), 64'(ft.busy));
          chk("flr_ack", 64'(flr_ack), 64'(ft.ack));
        end
      end
    end
  end

  initial begin : driver
    int offs[7];
    logic [AW-1:0] a;
    logic [NL-1:0] f;
    offs = '{'h00, 'h08, 'h28, 'h30, 'h10, 'h2C, 'h0C};
    bus.csr_req_valid = 1'b0; bus.csr_req_write = 1'b0; bus.csr_req_addr = '0;
    bus.csr_req_wdata = '0; bus.csr_req_wstrb = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_ready", 64'(bus.csr_req_ready), 64'd0);
    chk("reset_rsp_valid", 64'(bus.csr_rsp_valid), 64'd0);
    chk("reset_rdata", bus.csr_rsp_rdata, 64'd0);
    chk("reset_busy", 64'(flr_busy), 64'd0);
    chk("reset_ack", 64'(flr_ack), 64'd0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    #1 chk("ready_after_reset", 64'(bus.csr_req_ready), 64'd1);
    @(negedge clk);

    rd(20'h10000); rd(20'h10008);
    wr(20'h10028, 64'hDEADBEEF_CAFEF00D, 8'h0F); rd(20'h10028);
    wr(20'h10008, 64'h1234, 8'hFF); wr(20'h11008, 64'h55, 8'hFF); rd(20'h11008);
    step(1'b0, 1'b0, '0, 64'd0, 8'h00, 2'b10);
    repeat (6) idle();
    rd(20'h11008); rd(20'h11030); rd(20'h10008);
    step(1'b1, 1'b1, 20'h10008, 64'hA5, 8'hFF, 2'b01);
    repeat (6) idle();
    rd(20'h10008);
    step(1'b0, 1'b0, '0, 64'd0, 8'h00, 2'b01); idle();
    step(1'b0, 1'b0, '0, 64'd0, 8'h00, 2'b01);
    repeat (7) idle();
    rd(20'h10030);
    step(1'b0, 1'b0, '0, 64'd0, 8'h00, 2'b01);
    repeat (4) idle();
    step(1'b0, 1'b0, '0, 64'd0, 8'h00, 2'b01);
    repeat (3) idle();
    rd(20'h10030);

    step(1'b0, 1'b0, '0, 64'd0, 8'h00, 2'b01); idle(); idle();
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midflr_reset_busy", 64'(flr_busy), 64'd0);
    chk("midflr_reset_ack", 64'(flr_ack), 64'd0);
    chk("midflr_reset_ready", 64'(bus.csr_req_ready), 64'd0);
    repeat (2) @(negedge clk);
    rsp_q.delete(); flr_q.delete(); model_reset();
    rst_n = 1'b1;
    mon_en = 1'b1;
    repeat (6) idle();
    rd(20'h10030); rd(20'h11030); rd(20'h10028);

    for (int n = 0; n < 3000; n++) begin
      a = BASE + AW'($urandom_range(0, 2)) * AW'(STRIDE) + AW'(offs[$urandom_range(0, 6)]);
      if ($urandom_range(0, 19) == 0) a = 20'h0F008;
      f = '0;
      for (int i = 0; i < NL; i++) f[i] = ($urandom_range(0, 11) == 0);
      step($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), a, {$urandom, $urandom},
           8'($urandom), f);
    end
    repeat (8) idle();
    for (int i = 0; i < NL; i++) begin
      rd(BASE + AW'(i) * AW'(STRIDE) + 20'h30);
      rd(BASE + AW'(i) * AW'(STRIDE) + 20'h08);
    end
    repeat (3) idle();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
